// File: rtl/cdb_arbiter_if.sv
// Producer/consumer bundle for the common data bus arbiter.
// The master side drives the two producer result ports and observes the
// full flags, overflow and the registered CDB broadcast.
// The slave side (the arbiter) accepts pushes and drives the broadcast.
//   alu_valid/alu_rob_id/alu_value  : ALU result push
//   lsb_valid/lsb_rob_id/lsb_value  : LSB load-result push
//   alu_full/lsb_full               : per-producer FIFO full
//   cdb_valid/cdb_rob_id/cdb_value/cdb_src : registered broadcast
//   overflow                        : sticky push-while-full error
interface cdb_arbiter_if #(
  parameter int unsigned ROB_SIZE_WIDTH = 4
);
  logic                      alu_valid;
  logic [ROB_SIZE_WIDTH-1:0] alu_rob_id;
  logic [31:0]               alu_value;
  logic                      alu_full;

  logic                      lsb_valid;
  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id;
  logic [31:0]               lsb_value;
  logic                      lsb_full;

  logic                      cdb_valid;
  logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id;
  logic [31:0]               cdb_value;
  logic                      cdb_src;
  logic                      overflow;

  modport master (
    output alu_valid, alu_rob_id, alu_value,
    output lsb_valid, lsb_rob_id, lsb_value,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_rob_id, cdb_value, cdb_src, overflow
  );

  modport slave (
    input  alu_valid, alu_rob_id, alu_value,
    input  lsb_valid, lsb_rob_id, lsb_value,
    output alu_full, lsb_full,
    output cdb_valid, cdb_rob_id, cdb_value, cdb_src, overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two producer result FIFOs (index 0 = ALU,
// index 1 = LSB) drained one entry per cycle, round-robin, into a
// registered CDB broadcast.
// Ports:
//   clk        clock, posedge
//   rst        asynchronous active-low reset
//   rdy        global ready; 0 freezes all state
//   rob_clear  synchronous flush of all in-flight results
//   bus        cdb_arbiter_if.slave (pushes, full flags, broadcast, overflow)
module cdb_arbiter #(
  parameter int unsigned ROB_SIZE_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned FIFO_PTR_WIDTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          rob_clear,
  cdb_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W   = FIFO_PTR_WIDTH + 1;
  localparam int unsigned NUM_SRC = 2;

  // FIFO storage, indexed [source][entry]
  logic [ROB_SIZE_WIDTH-1:0] tag_mem [NUM_SRC][FIFO_DEPTH];
  logic [31:0]               val_mem [NUM_SRC][FIFO_DEPTH];

  logic [FIFO_PTR_WIDTH-1:0] wr_ptr_q [NUM_SRC];
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr_q [NUM_SRC];
  logic [CNT_W-1:0]          count_q  [NUM_SRC];

  logic                      cdb_valid_q;
  logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id_q;
  logic [31:0]               cdb_value_q;
  logic                      cdb_src_q;
  logic                      last_grant_q;
  logic                      overflow_q;

  // Per-source push view
  logic [NUM_SRC-1:0]        push_vld;
  logic [ROB_SIZE_WIDTH-1:0] push_tag [NUM_SRC];
  logic [31:0]               push_val [NUM_SRC];

  logic [NUM_SRC-1:0]        not_empty;
  logic [NUM_SRC-1:0]        full;
  logic [NUM_SRC-1:0]        push_ok;
  logic [NUM_SRC-1:0]        push_drop;
  logic [NUM_SRC-1:0]        pop;
  logic                      grant_valid;
  logic                      grant_src;
  logic [ROB_SIZE_WIDTH-1:0] head_tag;
  logic [31:0]               head_val;

  assign push_vld[0] = bus.alu_valid;
  assign push_vld[1] = bus.lsb_valid;
  assign push_tag[0] = bus.alu_rob_id;
  assign push_tag[1] = bus.lsb_rob_id;
  assign push_val[0] = bus.alu_value;
  assign push_val[1] = bus.lsb_value;

  // Occupancy, push admission and round-robin grant from registered counts;
  // a push accepted this cycle only becomes eligible next cycle.
  always_comb begin
    not_empty   = '0;
    full        = '0;
    push_ok     = '0;
    push_drop   = '0;
    pop         = '0;
    grant_valid = 1'b0;
    grant_src   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      not_empty[i] = (count_q[i] != '0);
      full[i]      = (count_q[i] == CNT_W'(FIFO_DEPTH));
      push_ok[i]   = push_vld[i] & ~full[i];
      push_drop[i] = push_vld[i] & full[i];
    end
    grant_valid = |not_empty;
    // Contention goes to the source that did not win last; otherwise the
    // only non-empty source wins.
    grant_src   = (&not_empty) ? ~last_grant_q : not_empty[1];
    pop[0]      = grant_valid & ~grant_src;
    pop[1]      = grant_valid & grant_src;
  end

  assign head_tag = tag_mem[grant_src][rd_ptr_q[grant_src]];
  assign head_val = val_mem[grant_src][rd_ptr_q[grant_src]];

  // Entry storage; contents need no reset since counts gate visibility.
  always_ff @(posedge clk) begin
    if (rdy && !rob_clear) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_ok[i]) begin
          tag_mem[i][wr_ptr_q[i]] <= push_tag[i];
          val_mem[i][wr_ptr_q[i]] <= push_val[i];
        end
      end
    end
  end

  // Pointers, counts, broadcast register, grant history and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else if (rdy) begin
      if (rob_clear) begin
        // Flush wins over push, pop and output load.
        for (int i = 0; i < NUM_SRC; i++) begin
          wr_ptr_q[i] <= '0;
          rd_ptr_q[i] <= '0;
          count_q[i]  <= '0;
        end
        cdb_valid_q <= 1'b0;
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (push_ok[i]) wr_ptr_q[i] <= wr_ptr_q[i] + FIFO_PTR_WIDTH'(1);
          if (pop[i])     rd_ptr_q[i] <= rd_ptr_q[i] + FIFO_PTR_WIDTH'(1);
          count_q[i] <= count_q[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
        end
        if (|push_drop) overflow_q <= 1'b1;
        if (grant_valid) begin
          cdb_valid_q  <= 1'b1;
          cdb_rob_id_q <= head_tag;
          cdb_value_q  <= head_val;
          cdb_src_q    <= grant_src;
          last_grant_q <= grant_src;
        end else begin
          cdb_valid_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.alu_full   = full[0];
  assign bus.lsb_full   = full[1];
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_value  = cdb_value_q;
  assign bus.cdb_src    = cdb_src_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued as
// stimulus is driven and popped whenever the CDB shows a new result.
module tb_cdb_arbiter;
  localparam int unsigned RW = 4;
  typedef logic [RW+32:0] exp_t;  // {rob_id, value, src}

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  logic rob_clear = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.ROB_SIZE_WIDTH(RW)) bus ();

  cdb_arbiter #(
    .ROB_SIZE_WIDTH(RW),
    .FIFO_DEPTH    (4),
    .FIFO_PTR_WIDTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rob_clear(rob_clear),
    .bus      (bus)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [RW-1:0] at, input logic [31:0] aval,
                       input logic lv, input logic [RW-1:0] lt, input logic [31:0] lval);
    bus.alu_valid  = av;
    bus.alu_rob_id = at;
    bus.alu_value  = aval;
    bus.lsb_valid  = lv;
    bus.lsb_rob_id = lt;
    bus.lsb_value  = lval;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic expect_out(input logic [RW-1:0] tag, input logic [31:0] val, input logic src);
    exp_q.push_back({tag, val, src});
  endtask

  // One clock edge; any new broadcast is matched against the scoreboard.
  task automatic tick();
    logic rdy_s;
    exp_t e;
    rdy_s = rdy;
    @(posedge clk);
    #1;
    if (rdy_s && bus.cdb_valid === 1'b1) begin
      check("cdb_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cdb_data", 64'({bus.cdb_rob_id, bus.cdb_value, bus.cdb_src}), 64'(e));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rdy = 1'b1;
    rob_clear = 1'b0;
    idle();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    do_reset();
    check("reset_state", 64'({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.cdb_src,
                              bus.alu_full, bus.lsb_full, bus.overflow}), 64'd0);

    // Single push latency: visible 2 edges later for one cycle
    drive(1'b1, 4'd3, 32'h11, 1'b0, '0, '0);
    expect_out(4'd3, 32'h11, 1'b0);
    tick();
    check("t1_edge1_valid", 64'(bus.cdb_valid), 64'd0);
    idle();
    tick();
    check("t1_edge2_valid", 64'(bus.cdb_valid), 64'd1);
    tick();
    check("t1_edge3_valid", 64'(bus.cdb_valid), 64'd0);

    // Continuous contention alternates ALU/LSB with no gaps
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, RW'(k + 1), 32'h100 + 32'(k + 1), 1'b1, RW'(k + 9), 32'h200 + 32'(k + 9));
      expect_out(RW'(k + 1), 32'h100 + 32'(k + 1), 1'b0);
      expect_out(RW'(k + 9), 32'h200 + 32'(k + 9), 1'b1);
      tick();
      if (k > 0) check("t2_no_gap", 64'(bus.cdb_valid), 64'd1);
    end
    idle();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_no_gap", 64'(bus.cdb_valid), 64'd1);
    end
    tick();
    check("t2_done_valid", 64'(bus.cdb_valid), 64'd0);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Fill the ALU FIFO under contention, then push while full
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, RW'(k + 1), 32'h100 + 32'(k + 1), 1'b1, RW'(k + 9), 32'h200 + 32'(k + 9));
      expect_out(RW'(k + 1), 32'h100 + 32'(k + 1), 1'b0);
      expect_out(RW'(k + 9), 32'h200 + 32'(k + 9), 1'b1);
      tick();
    end
    drive(1'b1, 4'd7, 32'h107, 1'b0, '0, '0);
    expect_out(4'd7, 32'h107, 1'b0);
    tick();
    check("t3_alu_full", 64'(bus.alu_full), 64'd1);
    check("t3_no_overflow_yet", 64'(bus.overflow), 64'd0);
    // Full at this edge even though the head pops: push must be dropped
    drive(1'b1, 4'd8, 32'h108, 1'b0, '0, '0);
    tick();
    check("t3_overflow_set", 64'(bus.overflow), 64'd1);
    check("t3_alu_not_full", 64'(bus.alu_full), 64'd0);
    idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("t3_drained", 64'(exp_q.size()), 64'd0);
    tick();
    check("t3_idle_valid", 64'(bus.cdb_valid), 64'd0);
    check("t3_overflow_sticky", 64'(bus.overflow), 64'd1);

    // rob_clear flushes queued work and a same-cycle push
    do_reset();
    drive(1'b1, 4'd1, 32'h101, 1'b1, 4'd9, 32'h209);
    expect_out(4'd1, 32'h101, 1'b0);
    tick();
    drive(1'b1, 4'd2, 32'h102, 1'b1, 4'd10, 32'h20a);
    tick();
    check("t4_pre_clear_valid", 64'(bus.cdb_valid), 64'd1);
    rob_clear = 1'b1;
    drive(1'b1, 4'd3, 32'h103, 1'b0, '0, '0);
    tick();
    rob_clear = 1'b0;
    idle();
    check("t4_clear_valid", 64'(bus.cdb_valid), 64'd0);
    check("t4_clear_full", 64'({bus.alu_full, bus.lsb_full}), 64'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t4_flushed_quiet", 64'(bus.cdb_valid), 64'd0);
    end
    drive(1'b1, 4'd7, 32'h107, 1'b0, '0, '0);
    expect_out(4'd7, 32'h107, 1'b0);
    tick();
    check("t4_tag7_edge1", 64'(bus.cdb_valid), 64'd0);
    idle();
    tick();
    check("t4_tag7_edge2", 64'(bus.cdb_valid), 64'd1);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // rdy=0 freezes outputs and ignores pushes
    do_reset();
    drive(1'b1, 4'd5, 32'h105, 1'b1, 4'd6, 32'h206);
    expect_out(4'd5, 32'h105, 1'b0);
    expect_out(4'd6, 32'h206, 1'b1);
    tick();
    drive(1'b1, 4'd7, 32'h107, 1'b0, '0, '0);
    expect_out(4'd7, 32'h107, 1'b0);
    tick();
    rdy = 1'b0;
    drive(1'b1, 4'd14, 32'h10e, 1'b1, 4'd15, 32'h20f);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_hold", 64'({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.cdb_src}),
            64'({1'b1, 4'd5, 32'h105, 1'b0}));
    end
    rdy = 1'b1;
    idle();
    tick();
    tick();
    tick();
    check("t5_after_valid", 64'(bus.cdb_valid), 64'd0);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-cycle with work in flight
    do_reset();
    drive(1'b1, 4'd1, 32'h101, 1'b1, 4'd9, 32'h209);
    expect_out(4'd1, 32'h101, 1'b0);
    expect_out(4'd9, 32'h209, 1'b1);
    tick();
    drive(1'b1, 4'd2, 32'h102, 1'b1, 4'd10, 32'h20a);
    tick();
    idle();
    check("t6_pre_reset_valid", 64'(bus.cdb_valid), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    check("t6_async_reset", 64'({bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.cdb_src,
                                 bus.alu_full, bus.lsb_full, bus.overflow}), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t6_after_reset_quiet", 64'(bus.cdb_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
